dma_priority_timing: RTL and testbench

DMA_PRIORITY_TIMING -- requirements
Module: dma_priority_timing

---
 rtl/dma_priority_timing.sv | 172 +++++++++++++++++
 tb/tb_dma_priority_timing.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_timing.sv
// ============================================================================
// Module      : dma_priority_timing
// Description : DMA channel arbiter and single-transfer bus timing FSM (SI, S0-S4)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_priority_timing #(
    parameter int CHANNELS = 4      // only 4 channels are supported
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [CHANNELS-1:0]     DREQ,
    input  logic                    HLDA,
    input  logic                    EOP_N,
    input  logic [7:0]              commandReg,
    input  logic [2*CHANNELS-1:0]   modeTransfer,
    input  logic [CHANNELS-1:0]     terminalCount,
    output logic                    HRQ,
    output logic [CHANNELS-1:0]     DACK,
    output logic                    AEN,
    output logic                    ADSTB,
    output logic                    MEMR_N,
    output logic                    MEMW_N,
    output logic                    IOR_N,
    output logic                    IOW_N,
    output logic                    programCondition,
    output logic                    loadAddr,
    output logic                    updateCurrentAddressReg,
    output logic                    updateCurrentWordCountReg,
    output logic                    intEOP
);

    localparam int c_chanWidth = $clog2(CHANNELS);

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        S4 = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic [c_chanWidth-1:0]   r_channel;
    logic [c_chanWidth-1:0]   r_prioPtr;
    logic                     r_eopSeen;

    logic                     w_anyReq;
    logic                     w_disable;
    logic                     w_rotate;
    logic [c_chanWidth-1:0]   w_base;
    logic [c_chanWidth-1:0]   w_candIdx;
    logic [c_chanWidth-1:0]   w_grantIdx;
    logic                     w_found;
    logic                     w_eopEvent;
    logic [1:0]               w_mode;
    logic                     w_unusedCmdBits;

    assign w_anyReq        = |DREQ;
    assign w_disable       = commandReg[2];
    assign w_rotate        = commandReg[4];
    assign w_mode          = modeTransfer[{r_channel, 1'b0} +: 2];
    assign w_eopEvent      = !EOP_N || ((r_state == S3) && terminalCount[r_channel]);
    assign w_unusedCmdBits = ^{commandReg[7:5], commandReg[3], commandReg[1:0]};

    // Search starts at the pointer (rotating) or ch0 (fixed); index wraps modulo 4.
    always_comb begin
        w_base     = w_rotate ? r_prioPtr : '0;
        w_grantIdx = '0;
        w_candIdx  = '0;
        w_found    = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_candIdx = w_base + k[c_chanWidth-1:0];
            if (!w_found && DREQ[w_candIdx]) begin
                w_grantIdx = w_candIdx;
                w_found    = 1'b1;
            end
        end
    end

    // A request that vanishes in S0 wins over a simultaneous grant: nothing to service.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SI: if (w_anyReq && !w_disable) w_nextState = S0;
            S0: begin
                if (!w_anyReq)  w_nextState = SI;
                else if (HLDA)  w_nextState = S1;
            end
            S1:      w_nextState = HLDA ? S2 : SI;
            S2:      w_nextState = HLDA ? S3 : SI;
            S3:      w_nextState = HLDA ? S4 : SI;
            S4:      w_nextState = SI;
            default: w_nextState = SI;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= SI;
            r_channel <= '0;
            r_prioPtr <= '0;
            r_eopSeen <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == S0) && (w_nextState == S1))
                r_channel <= w_grantIdx;
            // Rotation only on a completed transfer; aborts leave the pointer alone.
            if ((r_state == S4) && w_rotate)
                r_prioPtr <= r_channel + 1'b1;
            case (r_state)
                S2, S3:  r_eopSeen <= r_eopSeen | w_eopEvent;
                S4:      r_eopSeen <= r_eopSeen;
                default: r_eopSeen <= 1'b0;
            endcase
        end
    end

    always_comb begin
        HRQ                       = 1'b0;
        DACK                      = '0;
        AEN                       = 1'b0;
        ADSTB                     = 1'b0;
        MEMR_N                    = 1'b1;
        MEMW_N                    = 1'b1;
        IOR_N                     = 1'b1;
        IOW_N                     = 1'b1;
        programCondition          = 1'b0;
        loadAddr                  = 1'b0;
        updateCurrentAddressReg   = 1'b0;
        updateCurrentWordCountReg = 1'b0;
        intEOP                    = 1'b0;
        case (r_state)
            SI: programCondition = 1'b1;
            S0: HRQ = 1'b1;
            S1: begin
                HRQ             = 1'b1;
                AEN             = 1'b1;
                ADSTB           = 1'b1;
                loadAddr        = 1'b1;
                DACK[r_channel] = 1'b1;
            end
            S2, S3: begin
                HRQ             = 1'b1;
                AEN             = 1'b1;
                DACK[r_channel] = 1'b1;
                if (w_mode == 2'b10) begin
                    MEMR_N = 1'b0;
                    IOW_N  = 1'b0;
                end else if (w_mode == 2'b01) begin
                    IOR_N  = 1'b0;
                    MEMW_N = 1'b0;
                end
            end
            S4: begin
                HRQ                       = 1'b1;
                AEN                       = 1'b1;
                DACK[r_channel]           = 1'b1;
                updateCurrentAddressReg   = 1'b1;
                updateCurrentWordCountReg = 1'b1;
                intEOP                    = r_eopSeen;
            end
            default: programCondition = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_priority_timing.sv
// ============================================================================
// Module      : tb_dma_priority_timing
// Description : Directed self-checking bench for dma_priority_timing
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_priority_timing;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic [3:0] DREQ = 4'b0000;
    logic       HLDA = 1'b0;
    logic       EOP_N = 1'b1;
    logic [7:0] commandReg = 8'h00;
    logic [7:0] modeTransfer = 8'h55;
    logic [3:0] terminalCount = 4'b0000;

    logic       HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N;
    logic [3:0] DACK;
    logic       programCondition, loadAddr, updA, updW, intEOP;
    logic [15:0] obs;

    int nChecks = 0;
    int nFails  = 0;

    dma_priority_timing #(.CHANNELS(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N(EOP_N),
        .commandReg(commandReg), .modeTransfer(modeTransfer), .terminalCount(terminalCount),
        .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .programCondition(programCondition), .loadAddr(loadAddr),
        .updateCurrentAddressReg(updA), .updateCurrentWordCountReg(updW), .intEOP(intEOP)
    );

    always #5 CLK = ~CLK;

    // Packed view: {HRQ, DACK[3:0], AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, programCondition, loadAddr, updA, updW, intEOP}
    assign obs = {HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N,
                  programCondition, loadAddr, updA, updW, intEOP};

    localparam logic [3:0] STR_IDLE  = 4'b1111;
    localparam logic [3:0] STR_WRITE = 4'b1001;
    localparam logic [3:0] STR_READ  = 4'b0110;

    function automatic logic [15:0] eSI();
        return {1'b0, 4'b0000, 1'b0, 1'b0, STR_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [15:0] eS0();
        return {1'b1, 4'b0000, 1'b0, 1'b0, STR_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [15:0] eS1(input logic [3:0] d);
        return {1'b1, d, 1'b1, 1'b1, STR_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [15:0] eS23(input logic [3:0] d, input logic [3:0] s);
        return {1'b1, d, 1'b1, 1'b0, s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [15:0] eS4(input logic [3:0] d, input logic e);
        return {1'b1, d, 1'b1, 1'b0, STR_IDLE, 1'b0, 1'b0, 1'b1, 1'b1, e};
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #1 RESET_N = 1'b0;
        #1;
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL reset_async: got %b want %b", obs, eSI()); end
        cyc(); cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL reset_held: got %b want %b", obs, eSI()); end
        RESET_N = 1'b1;
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL reset_idle: got %b want %b", obs, eSI()); end
    endtask

    task automatic test_fixed_priority();
        DREQ = 4'b0101; HLDA = 1'b0;
        cyc();
        nChecks++; if (obs !== eS0()) begin nFails++; $display("FAIL fixed_s0: got %b want %b", obs, eS0()); end
        cyc(); cyc();
        nChecks++; if (obs !== eS0()) begin nFails++; $display("FAIL fixed_s0_wait: got %b want %b", obs, eS0()); end
        HLDA = 1'b1;
        cyc();
        nChecks++; if (obs !== eS1(4'b0001)) begin nFails++; $display("FAIL fixed_s1: got %b want %b", obs, eS1(4'b0001)); end
        cyc();
        nChecks++; if (obs !== eS23(4'b0001, STR_WRITE)) begin nFails++; $display("FAIL fixed_s2: got %b want %b", obs, eS23(4'b0001, STR_WRITE)); end
        cyc();
        nChecks++; if (obs !== eS23(4'b0001, STR_WRITE)) begin nFails++; $display("FAIL fixed_s3: got %b want %b", obs, eS23(4'b0001, STR_WRITE)); end
        cyc();
        nChecks++; if (obs !== eS4(4'b0001, 1'b0)) begin nFails++; $display("FAIL fixed_s4: got %b want %b", obs, eS4(4'b0001, 1'b0)); end
        DREQ = 4'b0100;
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL fixed_si: got %b want %b", obs, eSI()); end
        cyc();
        nChecks++; if (obs !== eS0()) begin nFails++; $display("FAIL fixed_s0_second: got %b want %b", obs, eS0()); end
        cyc();
        nChecks++; if (obs !== eS1(4'b0100)) begin nFails++; $display("FAIL fixed_next_ch2: got %b want %b", obs, eS1(4'b0100)); end
        cyc(); cyc(); cyc();
        DREQ = 4'b0000; HLDA = 1'b0;
        cyc();
    endtask

    task automatic test_rotating();
        logic [3:0] want;
        commandReg = 8'h10; DREQ = 4'b1111; HLDA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want = 4'b0001 << i;
            cyc();
            cyc();
            nChecks++; if (obs !== eS1(want)) begin nFails++; $display("FAIL rotate_%0d: got %b want %b", i, obs, eS1(want)); end
            cyc(); cyc(); cyc();
            if (i == 3) DREQ = 4'b0000;
            cyc();
        end
        commandReg = 8'h00; HLDA = 1'b0;
    endtask

    task automatic test_read_tc();
        modeTransfer = 8'b0000_1000; DREQ = 4'b0010; terminalCount = 4'b0010; HLDA = 1'b1;
        cyc();
        nChecks++; if (obs !== eS0()) begin nFails++; $display("FAIL read_s0: got %b want %b", obs, eS0()); end
        cyc();
        nChecks++; if (obs !== eS1(4'b0010)) begin nFails++; $display("FAIL read_s1: got %b want %b", obs, eS1(4'b0010)); end
        cyc();
        nChecks++; if (obs !== eS23(4'b0010, STR_READ)) begin nFails++; $display("FAIL read_s2: got %b want %b", obs, eS23(4'b0010, STR_READ)); end
        cyc();
        nChecks++; if (obs !== eS23(4'b0010, STR_READ)) begin nFails++; $display("FAIL read_s3: got %b want %b", obs, eS23(4'b0010, STR_READ)); end
        cyc();
        nChecks++; if (obs !== eS4(4'b0010, 1'b1)) begin nFails++; $display("FAIL read_tc_s4: got %b want %b", obs, eS4(4'b0010, 1'b1)); end
        DREQ = 4'b0000; terminalCount = 4'b0000;
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL read_si: got %b want %b", obs, eSI()); end
        modeTransfer = 8'h55; HLDA = 1'b0;
    endtask

    task automatic test_eop();
        DREQ = 4'b0001; HLDA = 1'b1;
        cyc(); cyc(); cyc();
        EOP_N = 1'b0;
        cyc();
        EOP_N = 1'b1;
        cyc();
        nChecks++; if (obs !== eS4(4'b0001, 1'b1)) begin nFails++; $display("FAIL eop_s4: got %b want %b", obs, eS4(4'b0001, 1'b1)); end
        DREQ = 4'b0000;
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL eop_si: got %b want %b", obs, eSI()); end
        HLDA = 1'b0;
    endtask

    task automatic test_abort();
        commandReg = 8'h10; DREQ = 4'b0011; HLDA = 1'b1;
        cyc(); cyc(); cyc();
        nChecks++; if (obs !== eS23(4'b0001, STR_WRITE)) begin nFails++; $display("FAIL abort_s2: got %b want %b", obs, eS23(4'b0001, STR_WRITE)); end
        HLDA = 1'b0;
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL abort_si: got %b want %b", obs, eSI()); end
        HLDA = 1'b1;
        cyc();
        cyc();
        nChecks++; if (obs !== eS1(4'b0001)) begin nFails++; $display("FAIL abort_no_rotate: got %b want %b", obs, eS1(4'b0001)); end
        cyc(); cyc(); cyc();
        nChecks++; if (obs !== eS4(4'b0001, 1'b0)) begin nFails++; $display("FAIL abort_retry_s4: got %b want %b", obs, eS4(4'b0001, 1'b0)); end
        DREQ = 4'b0000; commandReg = 8'h00;
        cyc();
        HLDA = 1'b0;
    endtask

    task automatic test_disable();
        commandReg = 8'h04; DREQ = 4'b1000; HLDA = 1'b0;
        cyc(); cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL disable_hold: got %b want %b", obs, eSI()); end
        commandReg = 8'h00;
        cyc();
        nChecks++; if (obs !== eS0()) begin nFails++; $display("FAIL enable_hrq: got %b want %b", obs, eS0()); end
        HLDA = 1'b1;
        cyc();
        nChecks++; if (obs !== eS1(4'b1000)) begin nFails++; $display("FAIL disable_s1: got %b want %b", obs, eS1(4'b1000)); end
        commandReg = 8'h04;
        cyc(); cyc(); cyc();
        nChecks++; if (obs !== eS4(4'b1000, 1'b0)) begin nFails++; $display("FAIL disable_mid_complete: got %b want %b", obs, eS4(4'b1000, 1'b0)); end
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL disable_mid_si: got %b want %b", obs, eSI()); end
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL disable_no_new_hrq: got %b want %b", obs, eSI()); end
        DREQ = 4'b0000; commandReg = 8'h00; HLDA = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        DREQ = 4'b0001; HLDA = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        nChecks++; if (obs !== eS23(4'b0001, STR_WRITE)) begin nFails++; $display("FAIL rst_s3_pre: got %b want %b", obs, eS23(4'b0001, STR_WRITE)); end
        #2 RESET_N = 1'b0;
        #1;
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL rst_async: got %b want %b", obs, eSI()); end
        DREQ = 4'b0000;
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL rst_held: got %b want %b", obs, eSI()); end
        RESET_N = 1'b1;
        cyc();
        nChecks++; if (obs !== eSI()) begin nFails++; $display("FAIL rst_release: got %b want %b", obs, eSI()); end
        HLDA = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_rotating();
        test_read_tc();
        test_eop();
        test_abort();
        test_disable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
